apb_rsp_collector: RTL and testbench

//  Downstream of the APB master, in parallel with the slave. Snoops completed APB transfers.

---
 rtl/apb_pkg.sv | 12 +
 rtl/rsp_fifo.sv | 54 +++++
 rtl/apb_rsp_collector.sv | 122 ++++++++++++
 tb/tb_apb_rsp_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB response collector.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_TMO
  } wd_state_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry.
module rsp_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  // Extra MSB on each pointer tells full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer is still taken.
  assign push_ok = push & (~full | pop_ok);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/apb_rsp_collector.sv
// Snoops completed APB transfers: buffers read data, pulses on writes, and
// flags access phases that stall beyond TIMEOUT wait states.
module apb_rsp_collector
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic                     pready_i,
  input  logic [DATA_W-1:0]        prdata_i,
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  input  logic                     rd_ready_i,
  output logic                     wr_done_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     timeout_o,
  input  logic                     timeout_clr_i
);

  localparam logic [7:0]       TmoCnt = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              cmpl, stall, rd_cmpl, wr_cmpl, pop, drop;
  logic              full, empty;
  logic [DATA_W-1:0] head;

  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              wr_done_q;
  logic              timeout_q, timeout_d, tmo_set;
  wd_state_t         state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  assign cmpl    = psel_i & penable_i & pready_i;
  assign stall   = psel_i & penable_i & ~pready_i;
  assign rd_cmpl = cmpl & ~pwrite_i;
  assign wr_cmpl = cmpl & pwrite_i;
  assign pop     = rd_valid_o & rd_ready_i;
  assign drop    = rd_cmpl & full & ~pop;

  rsp_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_cmpl),
    .push_data (prdata_i),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  assign rd_valid_o = ~empty;
  assign rd_data_o  = empty ? '0 : head;
  assign wr_done_o  = wr_done_q;
  assign drop_cnt_o = drop_cnt_q;
  assign timeout_o  = timeout_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CntOne;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_set    = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (stall) begin
          state_d    = W_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      W_WAIT: begin
        if (cmpl || !psel_i) begin
          state_d = W_IDLE;
        end else if (stall) begin
          if (wait_cnt_q == TmoCnt) begin
            state_d = W_TMO;
            tmo_set = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      W_TMO: begin
        if (cmpl || !psel_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
    // A new timeout outranks a simultaneous clear.
    timeout_d = tmo_set ? 1'b1 : (timeout_clr_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      wr_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
      state_q    <= W_IDLE;
      wait_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      wr_done_q  <= wr_cmpl;
      timeout_q  <= timeout_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_rsp_collector.sv
// Scoreboard bench for apb_rsp_collector: read data queued on completion, checked on pop.
module tb_apb_rsp_collector;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite, pready;
  logic [31:0] prdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        wr_done;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;
  logic        timeout;
  logic        timeout_clr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb[$];
  logic [7:0]  m_drop;

  always #5 clk = ~clk;

  apb_rsp_collector #(
    .DEPTH   (DEPTH),
    .DATA_W  (32),
    .TIMEOUT (15),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pready_i      (pready),
    .prdata_i      (prdata),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .rd_ready_i    (rd_ready),
    .wr_done_o     (wr_done),
    .level_o       (level),
    .drop_cnt_o    (drop_cnt),
    .timeout_o     (timeout),
    .timeout_clr_i (timeout_clr)
  );

  // Reference model of the response buffer and drop counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      m_drop <= 8'd0;
    end else begin
      if (sb.size() != 0 && rd_ready) void'(sb.pop_front());
      if (psel && penable && pready && !pwrite) begin
        if (sb.size() < DEPTH) sb.push_back(prdata);
        else if (m_drop != 8'hFF) m_drop <= m_drop + 8'd1;
      end
    end
  end

  function automatic logic [31:0] exp_head();
    return (sb.size() != 0) ? sb[0] : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] data, input int waits,
                          input logic rdy_on_cmpl);
    psel = 1'b1; penable = 1'b0; pwrite = wr; pready = 1'b0; prdata = data;
    tick();
    penable = 1'b1;
    for (int i = 0; i < waits; i++) tick();
    pready = 1'b1;
    if (rdy_on_cmpl) rd_ready = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pready = 1'b0; pwrite = 1'b0;
    if (rdy_on_cmpl) rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    psel = 0; penable = 0; pwrite = 0; pready = 0; prdata = '0;
    rd_ready = 0; timeout_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL reset_wr_done got %b want 0", wr_done); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    rd_ready = 1'b1;
    apb_xfer(1'b0, 32'hA5A5_0001, 0, 1'b0);
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 32'hA5A5_0001 || rd_data !== exp_head()) begin
      n_err++; $display("FAIL single_data got %h want %h", rd_data, exp_head()); end
    tick();
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_once got %b want 0", rd_valid); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level got %0d want 0", level); end
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) apb_xfer(1'b0, 32'(i), 0, 1'b0);
    @(negedge clk);
    n_cmp++; if (level !== 3'd4 || int'(level) != sb.size()) begin
      n_err++; $display("FAIL ovf_level got %0d want 4", level); end
    n_cmp++; if (drop_cnt !== 8'd1 || drop_cnt !== m_drop) begin
      n_err++; $display("FAIL ovf_drop got %0d want %0d", drop_cnt, m_drop); end
    tick();
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'(i) || rd_data !== exp_head()) begin
        n_err++; $display("FAIL ovf_drain%0d got %h/%b want %h", i, rd_data, rd_valid, i); end
      tick();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0 || level !== 3'd0) begin
      n_err++; $display("FAIL ovf_empty got v=%b d=%h l=%0d want 0/0/0", rd_valid, rd_data, level); end
  endtask

  task automatic test_full_pop();
    for (int i = 10; i <= 13; i++) apb_xfer(1'b0, 32'(i), 0, 1'b0);
    apb_xfer(1'b0, 32'd14, 1, 1'b1);
    @(negedge clk);
    n_cmp++; if (level !== 3'd4 || int'(level) != sb.size()) begin
      n_err++; $display("FAIL fullpop_level got %0d want 4", level); end
    n_cmp++; if (drop_cnt !== 8'd1 || drop_cnt !== m_drop) begin
      n_err++; $display("FAIL fullpop_drop got %0d want %0d", drop_cnt, m_drop); end
    tick();
    rd_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      @(negedge clk);
      n_cmp++; if (rd_data !== 32'(i) || rd_data !== exp_head()) begin
        n_err++; $display("FAIL fullpop_drain%0d got %h want %h", i, rd_data, i); end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; pready = 1'b0;
    tick();
    penable = 1'b1; pready = 1'b1;
    @(negedge clk);
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL b2b_pre got %b want 0", wr_done); end
    tick();
    @(negedge clk);
    n_cmp++; if (wr_done !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b want 1", wr_done); end
    tick();
    psel = 1'b0; penable = 1'b0; pready = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_done !== 1'b1) begin n_err++; $display("FAIL b2b_second got %b want 1", wr_done); end
    tick();
    @(negedge clk);
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", wr_done); end
    n_cmp++; if (level !== 3'd0 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_buffer got l=%0d v=%b want 0/0", level, rd_valid); end
  endtask

  task automatic test_watchdog();
    apb_xfer(1'b1, 32'd0, 15, 1'b0);
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_15 got %b want 0", timeout); end
    apb_xfer(1'b1, 32'd0, 16, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL wd_16 got %b want 1", timeout); end
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_clr got %b want 0", timeout); end
    // Clear held through the setting edge: the set must still land.
    timeout_clr = 1'b1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; pready = 1'b0;
    tick();
    penable = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL wd_set_wins got %b want 1", timeout); end
    tick();
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_clr_after got %b want 0", timeout); end
    timeout_clr = 1'b0;
    pready = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pready = 1'b0; pwrite = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) apb_xfer(1'b0, 32'hC0DE_0000 + 32'(i), 0, 1'b0);
    @(negedge clk);
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL rmid_level got %0d want 3", level); end
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; pready = 1'b0;
    tick();
    penable = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #2;
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0 || level !== 3'd0) begin
      n_err++; $display("FAIL rmid_buf got v=%b d=%h l=%0d want 0/0/0", rd_valid, rd_data, level); end
    n_cmp++; if (drop_cnt !== 8'd0 || wr_done !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL rmid_flags got d=%0d w=%b t=%b want 0/0/0", drop_cnt, wr_done, timeout); end
    tick();
    reset = 1'b0;
    // Stall continues across release; only 15 fresh wait cycles must count.
    for (int i = 0; i < 15; i++) tick();
    pready = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pready = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rmid_wd got %b want 0", timeout); end
    n_cmp++; if (wr_done !== 1'b1) begin n_err++; $display("FAIL rmid_wr_done got %b want 1", wr_done); end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
